// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one block memory port between the I-cache (r0) and D-cache (r1).
// Each cache owns a one-deep pending slot; a two-state FSM keeps exactly one memory request in flight.
module cache_mem_arbiter #(
  parameter int ADDRSIZE  = 32,
  parameter int BLOCKSIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_req_vld,
  input  logic                 r0_req_wen,
  input  logic [ADDRSIZE-1:0]  r0_addr,
  input  logic [BLOCKSIZE-1:0] r0_wr_data,
  output logic [BLOCKSIZE-1:0] r0_rd_data,
  output logic                 r0_req_done,
  input  logic                 r1_req_vld,
  input  logic                 r1_req_wen,
  input  logic [ADDRSIZE-1:0]  r1_addr,
  input  logic [BLOCKSIZE-1:0] r1_wr_data,
  output logic [BLOCKSIZE-1:0] r1_rd_data,
  output logic                 r1_req_done,
  output logic                 mem_req_vld,
  output logic                 mem_req_wen,
  output logic [ADDRSIZE-1:0]  mem_addr,
  output logic [BLOCKSIZE-1:0] mem_wr_data,
  input  logic [BLOCKSIZE-1:0] mem_rd_data,
  input  logic                 mem_req_done,
  output logic                 mem_gnt_id,
  output logic                 dbg_state
);

  // Handshake: a cache strobe is a single-cycle request that lands in its slot only when the slot
  // is empty. mem_req_vld stays high with all mem_* fields stable until mem_req_done is seen.
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t               r_state;
  logic                 r_last_gnt;
  logic [1:0]           r_pend;
  logic [1:0]           r_wen;
  logic [ADDRSIZE-1:0]  r_addr  [2];
  logic [BLOCKSIZE-1:0] r_wdata [2];
  logic [BLOCKSIZE-1:0] r_rd_data [2];
  logic [1:0]           r_done;
  logic                 r_mem_vld;
  logic                 r_mem_wen;
  logic [ADDRSIZE-1:0]  r_mem_addr;
  logic [BLOCKSIZE-1:0] r_mem_wdata;
  logic                 r_gnt;

  logic [1:0]           w_vld;
  logic [1:0]           w_wen;
  logic [ADDRSIZE-1:0]  w_addr  [2];
  logic [BLOCKSIZE-1:0] w_wdata [2];
  logic                 w_win;

  assign w_vld      = {r1_req_vld, r0_req_vld};
  assign w_wen      = {r1_req_wen, r0_req_wen};
  assign w_addr[0]  = r0_addr;
  assign w_addr[1]  = r1_addr;
  assign w_wdata[0] = r0_wr_data;
  assign w_wdata[1] = r1_wr_data;

  // On a tie the requester that did not win last time goes first; otherwise the sole pending one.
  assign w_win = (&r_pend) ? ~r_last_gnt : r_pend[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_last_gnt  <= 1'b1;
      r_pend      <= '0;
      r_wen       <= '0;
      r_done      <= '0;
      r_mem_vld   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gnt       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]    <= '0;
        r_wdata[i]   <= '0;
        r_rd_data[i] <= '0;
      end
    end else begin
      r_done <= '0;
      for (int i = 0; i < 2; i++) begin
        if (w_vld[i] && !r_pend[i]) begin
          r_pend[i]  <= 1'b1;
          r_wen[i]   <= w_wen[i];
          r_addr[i]  <= w_addr[i];
          r_wdata[i] <= w_wdata[i];
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_state     <= ST_BUSY;
            r_mem_vld   <= 1'b1;
            r_gnt       <= w_win;
            r_mem_wen   <= r_wen[w_win];
            r_mem_addr  <= r_addr[w_win];
            r_mem_wdata <= r_wdata[w_win];
          end
        end
        ST_BUSY: begin
          if (mem_req_done) begin
            r_state       <= ST_IDLE;
            r_mem_vld     <= 1'b0;
            r_done[r_gnt] <= 1'b1;
            r_pend[r_gnt] <= 1'b0;
            r_last_gnt    <= r_gnt;
            if (!r_mem_wen) r_rd_data[r_gnt] <= mem_rd_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign r0_rd_data  = r_rd_data[0];
  assign r1_rd_data  = r_rd_data[1];
  assign r0_req_done = r_done[0];
  assign r1_req_done = r_done[1];
  assign mem_req_vld = r_mem_vld;
  assign mem_req_wen = r_mem_wen;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wdata;
  assign mem_gnt_id  = r_gnt;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: single read, round-robin ties, writeback with queued read,
// ignored re-strobe, stray memory done, and reset in the middle of a transaction.
module tb_cache_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic         r0_req_vld, r0_req_wen, r1_req_vld, r1_req_wen;
  logic [31:0]  r0_addr, r1_addr;
  logic [127:0] r0_wr_data, r1_wr_data, r0_rd_data, r1_rd_data;
  logic         r0_req_done, r1_req_done;
  logic         mem_req_vld, mem_req_wen, mem_req_done, mem_gnt_id, dbg_state;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wr_data, mem_rd_data;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] D_AA = {16{8'hAA}};
  localparam logic [127:0] D1   = {16{8'h11}};
  localparam logic [127:0] D2   = {16{8'h22}};
  localparam logic [127:0] D3   = {16{8'h33}};
  localparam logic [127:0] D4   = {16{8'h44}};
  localparam logic [127:0] D55  = {16{8'h55}};
  localparam logic [127:0] DDE  = {8{16'hDEAD}};
  localparam logic [127:0] R4   = {4{32'hCAFE_F00D}};
  localparam logic [127:0] WB   = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  cache_mem_arbiter #(.ADDRSIZE(32), .BLOCKSIZE(128)) dut (
    .clk(clk), .rst(rst),
    .r0_req_vld(r0_req_vld), .r0_req_wen(r0_req_wen), .r0_addr(r0_addr), .r0_wr_data(r0_wr_data),
    .r0_rd_data(r0_rd_data), .r0_req_done(r0_req_done),
    .r1_req_vld(r1_req_vld), .r1_req_wen(r1_req_wen), .r1_addr(r1_addr), .r1_wr_data(r1_wr_data),
    .r1_rd_data(r1_rd_data), .r1_req_done(r1_req_done),
    .mem_req_vld(mem_req_vld), .mem_req_wen(mem_req_wen), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_req_done(mem_req_done),
    .mem_gnt_id(mem_gnt_id), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    r0_req_vld = 0; r0_req_wen = 0; r0_addr = '0; r0_wr_data = '0;
    r1_req_vld = 0; r1_req_wen = 0; r1_addr = '0; r1_wr_data = '0;
    mem_req_done = 0; mem_rd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // Memory model driver: waits (bounded) for a request, records it, answers after lat cycles.
  // Returns one cycle after mem_req_done, i.e. in the cycle the cache done pulse is expected.
  task automatic serve(input logic [127:0] rdata, input int lat, output logic ok,
                       output logic gnt, output logic wen, output logic [31:0] addr,
                       output logic [127:0] wdata);
    ok = 0; gnt = 0; wen = 0; addr = '0; wdata = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (mem_req_vld === 1'b1) ok = 1;
      else step();
    end
    if (!ok) return;
    gnt = mem_gnt_id; wen = mem_req_wen; addr = mem_addr; wdata = mem_wr_data;
    repeat (lat) step();
    mem_req_done = 1'b1; mem_rd_data = rdata;
    step();
    mem_req_done = 1'b0; mem_rd_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    r0_req_vld = 0; r0_req_wen = 0; r0_addr = '0; r0_wr_data = '0;
    r1_req_vld = 0; r1_req_wen = 0; r1_addr = '0; r1_wr_data = '0;
    mem_req_done = 0; mem_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({mem_req_vld, mem_req_wen, mem_gnt_id, r0_req_done, r1_req_done, dbg_state} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000",
        {mem_req_vld, mem_req_wen, mem_gnt_id, r0_req_done, r1_req_done, dbg_state}); end
    checks++; if ({mem_addr, mem_wr_data, r0_rd_data, r1_rd_data} !== '0) begin
      failures++; $display("FAIL reset_data got addr=%h rd0=%h rd1=%h exp=0", mem_addr, r0_rd_data, r1_rd_data); end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++; if (mem_req_vld !== 1'b0) begin failures++; $display("FAIL reset_idle vld got=%b exp=0", mem_req_vld); end
  endtask

  task automatic test_single_read();
    r0_req_vld = 1; r0_req_wen = 0; r0_addr = 32'h0000_1230;
    step();
    r0_req_vld = 0;
    checks++; if (mem_req_vld !== 1'b0) begin failures++; $display("FAIL t1_vld_c1 got=%b exp=0", mem_req_vld); end
    step();
    for (int c = 2; c <= 5; c++) begin
      checks++; if (mem_req_vld !== 1'b1) begin failures++; $display("FAIL t1_vld_c%0d got=%b exp=1", c, mem_req_vld); end
      if (c == 2) begin
        checks++; if ({mem_gnt_id, mem_req_wen, mem_addr} !== {1'b0, 1'b0, 32'h0000_1230}) begin
          failures++; $display("FAIL t1_req got gnt=%b wen=%b addr=%h exp gnt=0 wen=0 addr=00001230",
            mem_gnt_id, mem_req_wen, mem_addr); end
      end
      if (c == 5) begin mem_req_done = 1; mem_rd_data = D_AA; end
      step();
    end
    mem_req_done = 0; mem_rd_data = '0;
    checks++; if ({r0_req_done, r1_req_done, mem_req_vld} !== 3'b100) begin
      failures++; $display("FAIL t1_done_c6 got r0=%b r1=%b vld=%b exp 1 0 0", r0_req_done, r1_req_done, mem_req_vld); end
    checks++; if (r0_rd_data !== D_AA) begin failures++; $display("FAIL t1_rd0 got=%h exp=%h", r0_rd_data, D_AA); end
    checks++; if (r1_rd_data !== '0) begin failures++; $display("FAIL t1_rd1 got=%h exp=0", r1_rd_data); end
    step();
    checks++; if (r0_req_done !== 1'b0) begin failures++; $display("FAIL t1_done_c7 got=%b exp=0", r0_req_done); end
  endtask

  task automatic test_round_robin();
    logic ok, g, w; logic [31:0] a; logic [127:0] wd;
    do_reset();
    r0_req_vld = 1; r1_req_vld = 1; r0_req_wen = 0; r1_req_wen = 0;
    r0_addr = 32'h100; r1_addr = 32'h200;
    step();
    r0_req_vld = 0; r1_req_vld = 0;
    serve(D1, 2, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b0, 32'h100}) begin
      failures++; $display("FAIL t2_g1 got ok=%b gnt=%b addr=%h exp ok=1 gnt=0 addr=100", ok, g, a); end
    checks++; if ({r0_req_done, r1_req_done} !== 2'b10 || r0_rd_data !== D1) begin
      failures++; $display("FAIL t2_d1 got d0=%b d1=%b rd0=%h exp 1 0 %h", r0_req_done, r1_req_done, r0_rd_data, D1); end
    serve(D2, 1, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b1, 32'h200}) begin
      failures++; $display("FAIL t2_g2 got ok=%b gnt=%b addr=%h exp ok=1 gnt=1 addr=200", ok, g, a); end
    checks++; if ({r0_req_done, r1_req_done} !== 2'b01 || r1_rd_data !== D2) begin
      failures++; $display("FAIL t2_d2 got d0=%b d1=%b rd1=%h exp 0 1 %h", r0_req_done, r1_req_done, r1_rd_data, D2); end
    r0_req_vld = 1; r1_req_vld = 1; r0_addr = 32'h300; r1_addr = 32'h400;
    step();
    r0_req_vld = 0; r1_req_vld = 0;
    serve(D3, 0, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b0, 32'h300}) begin
      failures++; $display("FAIL t2_g3 got ok=%b gnt=%b addr=%h exp ok=1 gnt=0 addr=300", ok, g, a); end
    checks++; if ({r0_req_done, r1_req_done} !== 2'b10 || r0_rd_data !== D3) begin
      failures++; $display("FAIL t2_d3 got d0=%b d1=%b rd0=%h exp 1 0 %h", r0_req_done, r1_req_done, r0_rd_data, D3); end
    serve(D4, 3, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b1, 32'h400}) begin
      failures++; $display("FAIL t2_g4 got ok=%b gnt=%b addr=%h exp ok=1 gnt=1 addr=400", ok, g, a); end
    checks++; if ({r0_req_done, r1_req_done} !== 2'b01 || r1_rd_data !== D4) begin
      failures++; $display("FAIL t2_d4 got d0=%b d1=%b rd1=%h exp 0 1 %h", r0_req_done, r1_req_done, r1_rd_data, D4); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({mem_req_vld, r0_req_done, r1_req_done} !== 3'b000) begin
        failures++; $display("FAIL t2_quiet%0d got vld=%b d0=%b d1=%b exp 0 0 0", c, mem_req_vld, r0_req_done, r1_req_done); end
    end
  endtask

  task automatic test_writeback_then_read();
    logic ok, g, w; logic [31:0] a; logic [127:0] wd;
    r1_req_vld = 1; r1_req_wen = 1; r1_addr = 32'h0004_0010; r1_wr_data = WB;
    step();
    r1_req_vld = 0; r1_req_wen = 0; r1_wr_data = '0;
    step();
    checks++; if ({mem_req_vld, mem_gnt_id} !== 2'b11) begin
      failures++; $display("FAIL t3_busy got vld=%b gnt=%b exp 1 1", mem_req_vld, mem_gnt_id); end
    r0_req_vld = 1; r0_req_wen = 0; r0_addr = 32'h0000_5000;
    step();
    r0_req_vld = 0;
    serve(DDE, 2, ok, g, w, a, wd);
    checks++; if ({ok, g, w, a} !== {1'b1, 1'b1, 1'b1, 32'h0004_0010} || wd !== WB) begin
      failures++; $display("FAIL t3_wr got ok=%b gnt=%b wen=%b addr=%h data=%h exp 1 1 1 00040010 %h", ok, g, w, a, wd, WB); end
    checks++; if ({r1_req_done, r0_req_done, mem_req_vld} !== 3'b100 || r1_rd_data !== D4) begin
      failures++; $display("FAIL t3_wdone got d1=%b d0=%b vld=%b rd1=%h exp 1 0 0 %h", r1_req_done, r0_req_done, mem_req_vld, r1_rd_data, D4); end
    step();
    checks++; if ({mem_req_vld, mem_gnt_id, mem_req_wen, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h0000_5000}) begin
      failures++; $display("FAIL t3_rd_gnt got vld=%b gnt=%b wen=%b addr=%h exp 1 0 0 00005000", mem_req_vld, mem_gnt_id, mem_req_wen, mem_addr); end
    serve(D55, 1, ok, g, w, a, wd);
    checks++; if (!ok || r0_req_done !== 1'b1 || r0_rd_data !== D55) begin
      failures++; $display("FAIL t3_rdone got ok=%b d0=%b rd0=%h exp 1 1 %h", ok, r0_req_done, r0_rd_data, D55); end
  endtask

  task automatic test_restrobe_ignored();
    logic ok, g, w; logic [31:0] a; logic [127:0] wd;
    r0_req_vld = 1; r0_req_wen = 0; r0_addr = 32'h700;
    step();
    r0_addr = 32'h800;
    step();
    r0_addr = 32'h900;
    step();
    r0_req_vld = 0;
    serve(R4, 1, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b0, 32'h700}) begin
      failures++; $display("FAIL t4_addr got ok=%b gnt=%b addr=%h exp 1 0 00000700", ok, g, a); end
    checks++; if (r0_req_done !== 1'b1 || r0_rd_data !== R4) begin
      failures++; $display("FAIL t4_done got d0=%b rd0=%h exp 1 %h", r0_req_done, r0_rd_data, R4); end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if ({mem_req_vld, r0_req_done} !== 2'b00) begin
        failures++; $display("FAIL t4_dup%0d got vld=%b d0=%b exp 0 0", c, mem_req_vld, r0_req_done); end
    end
  endtask

  task automatic test_stray_done();
    mem_req_done = 1; mem_rd_data = D_AA;
    step();
    mem_req_done = 0; mem_rd_data = '0;
    checks++; if ({r0_req_done, r1_req_done, mem_req_vld, dbg_state} !== 4'b0000) begin
      failures++; $display("FAIL t5_ctrl got d0=%b d1=%b vld=%b st=%b exp 0 0 0 0", r0_req_done, r1_req_done, mem_req_vld, dbg_state); end
    step();
    checks++; if (r0_rd_data !== R4 || r1_rd_data !== D4 || r0_req_done !== 1'b0) begin
      failures++; $display("FAIL t5_data got rd0=%h rd1=%h d0=%b exp %h %h 0", r0_rd_data, r1_rd_data, r0_req_done, R4, D4); end
  endtask

  task automatic test_reset_mid_txn();
    logic ok, g, w; logic [31:0] a; logic [127:0] wd;
    r0_req_vld = 1; r0_req_wen = 0; r0_addr = 32'h0000_0A00;
    step();
    r0_req_vld = 0;
    step();
    r1_req_vld = 1; r1_req_wen = 0; r1_addr = 32'h0000_0B00;
    step();
    r1_req_vld = 0;
    checks++; if ({mem_req_vld, dbg_state} !== 2'b11) begin
      failures++; $display("FAIL t6_busy got vld=%b st=%b exp 1 1", mem_req_vld, dbg_state); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({mem_req_vld, dbg_state, r0_req_done, r1_req_done} !== 4'b0000 || r0_rd_data !== '0) begin
      failures++; $display("FAIL t6_async got vld=%b st=%b d0=%b d1=%b rd0=%h exp 0 0 0 0 0",
        mem_req_vld, dbg_state, r0_req_done, r1_req_done, r0_rd_data); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if ({mem_req_vld, r0_req_done, r1_req_done} !== 3'b000) begin
        failures++; $display("FAIL t6_cleared%0d got vld=%b d0=%b d1=%b exp 0 0 0", c, mem_req_vld, r0_req_done, r1_req_done); end
    end
    r1_req_vld = 1; r1_req_wen = 0; r1_addr = 32'h0004_0020;
    step();
    r1_req_vld = 0;
    serve(D2, 1, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b1, 32'h0004_0020} || r1_req_done !== 1'b1 || r1_rd_data !== D2) begin
      failures++; $display("FAIL t6_r1 got ok=%b gnt=%b addr=%h d1=%b rd1=%h exp 1 1 00040020 1 %h", ok, g, a, r1_req_done, r1_rd_data, D2); end
    r0_req_vld = 1; r1_req_vld = 1; r0_addr = 32'hC00; r1_addr = 32'hD00;
    step();
    r0_req_vld = 0; r1_req_vld = 0;
    serve(D3, 0, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b0, 32'hC00}) begin
      failures++; $display("FAIL t6_tie got ok=%b gnt=%b addr=%h exp 1 0 00000c00", ok, g, a); end
    serve(D4, 0, ok, g, w, a, wd);
    checks++; if ({ok, g, a} !== {1'b1, 1'b1, 32'hD00} || r1_rd_data !== D4) begin
      failures++; $display("FAIL t6_tie2 got ok=%b gnt=%b addr=%h rd1=%h exp 1 1 00000d00 %h", ok, g, a, r1_rd_data, D4); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_writeback_then_read();
    test_restrobe_ignored();
    test_stray_done();
    test_reset_mid_txn();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
